bht_lhist: RTL and testbench
============================

BHT_LHIST -- requirements
Module: bht_lhist

Interface
REQ-001 SHALL have parameter XLEN, default 32, virtual address width.
REQ-002 SHALL have parameter NR_ENTRIES, default 128, table rows; power of two, 2..1024.
REQ-003 SHALL have parameter HIST_LEN, default 3, local history bits per row, 1..6.
REQ-004 SHALL have parameter RVC, default 0, compressed-instruction support; selects PC index LSB.
REQ-005 SHALL have port clk_i, input, 1, the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_i, input, 1; reset is synchronous and active-high.
REQ-007 SHALL have port flush_i, input, 1, invalidates all rows.
REQ-008 SHALL have port debug_mode_i, input, 1, blocks updates when high.
REQ-009 SHALL have port vpc_i, input, XLEN, lookup PC.
REQ-010 SHALL have port upd_valid_i, input, 1, resolved-branch update strobe.
REQ-011 SHALL have port upd_pc_i, input, XLEN, resolved branch PC.
REQ-012 SHALL have port upd_taken_i, input, 1, resolved direction.
REQ-013 SHALL have port pred_valid_o, output, 1, the indexed row holds trained state.
REQ-014 SHALL have port pred_taken_o, output, 1, predicted direction.

Function
REQ-015 SHALL index a row by PC bits [IDXW+OFS-1:OFS], where IDXW=log2(NR_ENTRIES), OFS=1 if RVC else 2; upper bits ignored (no tags; aliasing allowed).
REQ-016 Each row SHALL hold a valid bit, a HIST_LEN-bit history register and 2^HIST_LEN 2-bit saturating counters.
REQ-017 Lookup SHALL be combinational: pred_valid_o = row valid; pred_taken_o = MSB of the counter selected by the row's current history; pred_taken_o = 0 when the row is invalid.
REQ-018 An update (upd_valid_i=1, debug_mode_i=0, flush_i=0) SHALL, at the next edge: select the counter by the row's pre-update history; increment it if taken, unless 3; decrement it if not taken, unless 0.
REQ-019 The same update SHALL shift the history left, inserting upd_taken_i at bit 0, discard the oldest bit, and set the row valid.
REQ-020 Update of an invalid row SHALL first treat history as 0 and counters as 2'b01, then apply REQ-018/019.
REQ-021 Lookup and update of the same row in one cycle SHALL return the pre-update state; the new state is visible the following cycle.
REQ-022 Updates with debug_mode_i=1 SHALL be dropped with no state change.
REQ-023 flush_i=1 SHALL clear every valid bit, history register and counter (to 2'b01) at the next edge; a simultaneous update is discarded.
REQ-024 The block SHALL have no stall or backpressure; one update per cycle is accepted unconditionally.

Reset
REQ-025 rst_i=1 at an edge SHALL set every row invalid, every history to 0 and every counter to 2'b01, overriding flush_i and updates.
REQ-026 While rst_i=1, pred_valid_o=0 and pred_taken_o=0 from the first edge with rst_i high.
REQ-027 Reset mid-training SHALL lose all state; the first post-reset lookup returns pred_valid_o=0.

Structure
REQ-028 The bht_update and bht_prediction struct typedefs and the RVC-dependent offset constant SHALL live in the shared core package.
REQ-029 The saturating counter update SHALL be one sub-module, sat_counter2 (2-bit, taken in, next value out), instantiated once on the update path.
REQ-030 Storage SHALL be flops, or FPGA distributed RAM with an identical read/write contract.

Verification (NR_ENTRIES=128, HIST_LEN=3, RVC=0)
REQ-031 Release reset, lookup vpc_i=0x8000_0010 -> pred_valid_o=0, pred_taken_o=0.
REQ-032 Three taken updates at 0x8000_0010, then lookup -> valid=1, history=3'b111, counters[0]=2, [1]=2, [3]=2, pred_taken_o=counters[7] MSB=0; four more taken updates -> pred_taken_o=1.
REQ-033 Alternating T,N pattern at 0x100 for 40 updates -> prediction matches the actual next outcome on the last 16 lookups.
REQ-034 Update 0x8000_0010 and 0x8000_0210 (same index 4) -> both share row 4; lookup of either PC returns identical outputs.
REQ-035 Same-cycle lookup and update of row 4 -> old value that cycle, new value the next cycle; update with debug_mode_i=1 -> no change.
REQ-036 flush_i together with upd_valid_i -> all rows invalid next cycle, update discarded; rst_i asserted mid-sequence -> all lookups valid=0.

Source files
------------

// File: rtl/bht_lhist_pkg.sv
// Shared types and constants for the local-history branch predictor.
// Latency: n/a (types, constants, helper function only).
// Backpressure: n/a.
package bht_lhist_pkg;

    // Prediction presented to fetch for the looked-up PC
    typedef struct packed {
        logic valid;
        logic taken;
    } bht_prediction_t;

    // Resolved-branch update after debug/flush qualification
    typedef struct packed {
        logic valid;
        logic taken;
    } bht_update_t;

    // Weakly-not-taken value loaded into every counter of a fresh row
    localparam logic [1:0] CTR_INIT = 2'b01;

    // Lowest PC bit used for indexing: halfword-aligned with RVC, word-aligned otherwise
    function automatic int unsigned pc_ofs(input int unsigned rvc);
        return (rvc != 0) ? 1 : 2;
    endfunction

endpackage

// File: rtl/bht_lhist_sat_counter2.sv
// 2-bit saturating up/down counter next-state logic.
// Latency: combinational.
// Backpressure: none.
module sat_counter2 (
    input  logic [1:0] i_cnt,
    input  logic       i_taken,
    output logic [1:0] o_cnt
);

    // Count toward taken/not-taken, holding at 3 and 0
    always_comb begin
        o_cnt = i_cnt;
        if (i_taken) begin
            if (i_cnt != 2'b11) o_cnt = i_cnt + 2'd1;
        end else begin
            if (i_cnt != 2'b00) o_cnt = i_cnt - 2'd1;
        end
    end

endmodule

// File: rtl/bht_lhist.sv
// Untagged local-history BHT: per-row history selects one of 2^HIST_LEN 2-bit counters.
// Latency: lookup combinational; update visible one cycle after the accepting edge.
// Backpressure: none; one update per cycle accepted, dropped under debug or flush.
module bht_lhist
    import bht_lhist_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned NR_ENTRIES = 128,
    parameter int unsigned HIST_LEN   = 3,
    parameter int unsigned RVC        = 0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            debug_mode_i,
    input  logic [XLEN-1:0] vpc_i,
    input  logic            upd_valid_i,
    input  logic [XLEN-1:0] upd_pc_i,
    input  logic            upd_taken_i,
    output logic            pred_valid_o,
    output logic            pred_taken_o
);

    localparam int unsigned IDXW = $clog2(NR_ENTRIES);
    localparam int unsigned OFS  = pc_ofs(RVC);
    localparam int unsigned CNT  = 1 << HIST_LEN;

    logic [NR_ENTRIES-1:0] r_valid;
    logic [HIST_LEN-1:0]   r_hist [NR_ENTRIES];
    logic [1:0]            r_ctr  [NR_ENTRIES][CNT];

    logic [IDXW-1:0]     w_lk_idx;
    logic [IDXW-1:0]     w_up_idx;
    logic [HIST_LEN-1:0] w_lk_hist;
    logic [HIST_LEN-1:0] w_up_hist;
    logic [HIST_LEN:0]   w_hist_shift;
    logic [HIST_LEN-1:0] w_new_hist;
    logic [1:0]          w_up_cnt;
    logic [1:0]          w_cnt_nxt;
    bht_update_t         w_upd;
    bht_prediction_t     w_pred;
    logic                w_unused_pc;

    // Untagged indexing: upper PC bits and sub-offset bits never reach the table
    assign w_lk_idx    = vpc_i[IDXW+OFS-1:OFS];
    assign w_up_idx    = upd_pc_i[IDXW+OFS-1:OFS];
    assign w_unused_pc = ^{vpc_i, upd_pc_i};

    // Lookup reads pre-edge state, so a same-cycle update is seen only next cycle
    assign w_lk_hist    = r_hist[w_lk_idx];
    assign w_pred.valid = r_valid[w_lk_idx];
    assign w_pred.taken = r_valid[w_lk_idx] & r_ctr[w_lk_idx][w_lk_hist][1];
    assign pred_valid_o = w_pred.valid;
    assign pred_taken_o = w_pred.taken;

    // Qualify the update and form its operands; an invalid row reads as fresh
    always_comb begin
        w_upd.valid = upd_valid_i & ~debug_mode_i & ~flush_i;
        w_upd.taken = upd_taken_i;
        w_up_hist   = '0;
        w_up_cnt    = CTR_INIT;
        if (r_valid[w_up_idx]) begin
            w_up_hist = r_hist[w_up_idx];
            w_up_cnt  = r_ctr[w_up_idx][w_up_hist];
        end
        w_hist_shift = {w_up_hist, w_upd.taken};
        w_new_hist   = w_hist_shift[HIST_LEN-1:0];
    end

    sat_counter2 u_sat_counter2 (
        .i_cnt   (w_up_cnt),
        .i_taken (w_upd.taken),
        .o_cnt   (w_cnt_nxt)
    );

    // Table state: reset/flush wipe every row; otherwise write back one qualified update
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            r_valid <= '0;
            for (int i = 0; i < NR_ENTRIES; i++) begin
                r_hist[i] <= '0;
                for (int j = 0; j < CNT; j++) begin
                    r_ctr[i][j] <= CTR_INIT;
                end
            end
        end else if (w_upd.valid) begin
            if (!r_valid[w_up_idx]) begin
                for (int j = 0; j < CNT; j++) begin
                    r_ctr[w_up_idx][j] <= CTR_INIT;
                end
            end
            r_ctr[w_up_idx][w_up_hist] <= w_cnt_nxt;
            r_hist[w_up_idx]           <= w_new_hist;
            r_valid[w_up_idx]          <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bht_lhist.sv
module tb_bht_lhist;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        flush_i;
    logic        debug_mode_i;
    logic [31:0] vpc_i;
    logic        upd_valid_i;
    logic [31:0] upd_pc_i;
    logic        upd_taken_i;
    logic        pred_valid_o;
    logic        pred_taken_o;

    always #5 clk_i = ~clk_i;

    bht_lhist #(
        .XLEN       (32),
        .NR_ENTRIES (128),
        .HIST_LEN   (3),
        .RVC        (0)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .flush_i      (flush_i),
        .debug_mode_i (debug_mode_i),
        .vpc_i        (vpc_i),
        .upd_valid_i  (upd_valid_i),
        .upd_pc_i     (upd_pc_i),
        .upd_taken_i  (upd_taken_i),
        .pred_valid_o (pred_valid_o),
        .pred_taken_o (pred_taken_o)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: plain per-row arrays of integers
    bit m_valid [128];
    int m_hist  [128];
    int m_ctr   [128][8];

    function automatic int row_of(input logic [31:0] pc);
        return int'((pc / 4) % 128);
    endfunction

    function automatic void model_clear();
        for (int r = 0; r < 128; r++) begin
            m_valid[r] = 0;
            m_hist[r]  = 0;
            for (int c = 0; c < 8; c++) m_ctr[r][c] = 1;
        end
    endfunction

    function automatic void model_update(input logic [31:0] pc, input bit taken);
        int r;
        int c;
        r = row_of(pc);
        if (!m_valid[r]) begin
            m_hist[r] = 0;
            for (int k = 0; k < 8; k++) m_ctr[r][k] = 1;
        end
        c = m_ctr[r][m_hist[r]];
        if (taken) c = (c == 3) ? 3 : c + 1;
        else       c = (c == 0) ? 0 : c - 1;
        m_ctr[r][m_hist[r]] = c;
        m_hist[r]  = (m_hist[r] * 2 + (taken ? 1 : 0)) % 8;
        m_valid[r] = 1;
    endfunction

    function automatic int model_pred_valid(input logic [31:0] pc);
        return m_valid[row_of(pc)] ? 1 : 0;
    endfunction

    function automatic int model_pred_taken(input logic [31:0] pc);
        int r;
        r = row_of(pc);
        if (!m_valid[r]) return 0;
        return (m_ctr[r][m_hist[r]] >= 2) ? 1 : 0;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input bit rst, input bit fl, input bit dbg, input bit uv,
                         input logic [31:0] upc, input bit ut, input logic [31:0] vpc);
        rst_i        = rst;
        flush_i      = fl;
        debug_mode_i = dbg;
        upd_valid_i  = uv;
        upd_pc_i     = upc;
        upd_taken_i  = ut;
        vpc_i        = vpc;
    endtask

    // Advance one edge and apply the same inputs to the model
    task automatic tick();
        @(posedge clk_i);
        if (rst_i || flush_i) model_clear();
        else if (upd_valid_i && !debug_mode_i) model_update(upd_pc_i, upd_taken_i);
        #1;
    endtask

    task automatic check_model(input string nm);
        #3;
        chk({nm, "_valid"}, int'(pred_valid_o), model_pred_valid(vpc_i));
        chk({nm, "_taken"}, int'(pred_taken_o), model_pred_taken(vpc_i));
    endtask

    typedef struct {
        bit          upd;
        bit          taken;
        bit          dbg;
        bit          flush;
        logic [31:0] upc;
        logic [31:0] vpc;
        bit          exp_v;
        bit          exp_t;
    } vec_t;

    localparam logic [31:0] PA = 32'h8000_0010;
    localparam logic [31:0] PB = 32'h8000_0210;

    vec_t vecs [17];
    logic [31:0] pcs [6];

    initial begin
        // Hand-derived expectations for row 4 (same-cycle lookup sees pre-edge state)
        vecs[0]  = '{0, 0, 0, 0, PA, PA, 0, 0};
        vecs[1]  = '{1, 1, 0, 0, PA, PA, 0, 0};
        vecs[2]  = '{1, 1, 0, 0, PA, PA, 1, 0};
        vecs[3]  = '{1, 1, 0, 0, PA, PA, 1, 0};
        vecs[4]  = '{0, 0, 0, 0, PA, PA, 1, 0};
        vecs[5]  = '{1, 1, 0, 0, PA, PA, 1, 0};
        vecs[6]  = '{1, 1, 0, 0, PA, PA, 1, 1};
        vecs[7]  = '{1, 1, 0, 0, PA, PA, 1, 1};
        vecs[8]  = '{1, 1, 0, 0, PB, PA, 1, 1};
        vecs[9]  = '{0, 0, 0, 0, PA, PB, 1, 1};
        vecs[10] = '{1, 0, 1, 0, PA, PA, 1, 1};
        vecs[11] = '{0, 0, 0, 0, PA, PB, 1, 1};
        vecs[12] = '{1, 0, 0, 0, PA, PA, 1, 1};
        vecs[13] = '{0, 0, 0, 0, PA, PA, 1, 0};
        vecs[14] = '{1, 1, 0, 1, PA, PA, 1, 0};
        vecs[15] = '{0, 0, 0, 0, PA, PA, 0, 0};
        vecs[16] = '{0, 0, 0, 0, PA, 32'h0000_0100, 0, 0};

        pcs[0] = PA;
        pcs[1] = PB;
        pcs[2] = 32'h0000_0100;
        pcs[3] = 32'h0000_0104;
        pcs[4] = 32'h0000_03FC;
        pcs[5] = 32'h1234_5600;

        model_clear();
        drive(1, 0, 0, 0, '0, 0, PA);
        tick();
        tick();

        // Directed table: training, aliasing, same-cycle visibility, debug drop, flush
        for (int i = 0; i < 17; i++) begin
            drive(0, vecs[i].flush, vecs[i].dbg, vecs[i].upd, vecs[i].upc, vecs[i].taken, vecs[i].vpc);
            #3;
            chk($sformatf("vec%0d_valid", i), int'(pred_valid_o), int'(vecs[i].exp_v));
            chk($sformatf("vec%0d_taken", i), int'(pred_taken_o), int'(vecs[i].exp_t));
            tick();
        end

        // Alternating T,N at one PC: after warm-up the prediction tracks the outcome
        drive(1, 0, 0, 0, '0, 0, '0);
        tick();
        for (int k = 0; k < 40; k++) begin
            drive(0, 0, 0, 1, 32'h0000_0100, (k % 2) == 0, 32'h0000_0100);
            check_model($sformatf("alt%0d", k));
            if (k >= 24) chk($sformatf("alt%0d_next", k), int'(pred_taken_o), (k % 2) == 0 ? 1 : 0);
            tick();
        end

        // Reset in the middle of training wipes everything
        for (int k = 0; k < 5; k++) begin
            drive(0, 0, 0, 1, PA, 1, PA);
            tick();
        end
        drive(1, 0, 0, 1, PA, 1, PA);
        check_model("rst_pre");
        tick();
        #3;
        chk("rst_hold_valid", int'(pred_valid_o), 0);
        chk("rst_hold_taken", int'(pred_taken_o), 0);
        tick();
        drive(0, 0, 0, 0, PA, 0, PA);
        #3;
        chk("rst_after_valid", int'(pred_valid_o), 0);
        tick();

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            logic [31:0] up;
            logic [31:0] lp;
            up = pcs[$urandom_range(5, 0)];
            lp = ($urandom_range(3, 0) == 0) ? up : pcs[$urandom_range(5, 0)];
            drive($urandom_range(99, 0) == 0,
                  $urandom_range(49, 0) == 0,
                  $urandom_range(7, 0) == 0,
                  $urandom_range(3, 0) != 0,
                  up, $urandom_range(1, 0) == 1, lp);
            check_model($sformatf("rnd%0d", n));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
